mem_blk_serdes: RTL and testbench

- Sits between the memory request arbiter and the memory controller's common data bus.
- Accepts one 512-bit cache-line transaction at a time (read or write) from the arbiter.
- Writes: serializes the line into 32-bit beats. Reads: assembles 32-bit beats into a line.
- Drives the controller's op/ready/tx_done/rd_valid handshake. Returns the assembled line, or a completion, to the arbiter.

---
 rtl/mem_blk_serdes_if.sv | 59 +++++
 rtl/mem_blk_serdes.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_blk_serdes.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_blk_serdes_if.sv
// Interfaces for mem_blk_serdes.
//
// mem_blk_serdes_req_if : arbiter side, one cache-line transaction at a time.
//   req_valid/req_wr/req_addr/req_wdata  arbiter -> serdes request
//   req_ready                            serdes idle, request accepted when high
//   resp_valid/resp_err/resp_rdata       serdes -> arbiter completion
//   modport master = arbiter, modport slave = serdes
//
// mem_blk_serdes_bus_if : memory controller common data bus.
//   op                          00 NOP, 01 READ, 10 WRITE
//   common_data_bus_write_out   address/data beat towards the controller
//   common_data_bus_read_in     read beat from the controller
//   ready/tx_done/rd_valid      controller handshake
//   modport master = serdes, modport slave = controller

interface mem_blk_serdes_req_if #(
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
);
    logic                     req_valid;
    logic                     req_wr;
    logic [ADDR_BITCOUNT-1:0] req_addr;
    logic [CL_SIZE_WIDTH-1:0] req_wdata;
    logic                     req_ready;
    logic                     resp_valid;
    logic                     resp_err;
    logic [CL_SIZE_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

interface mem_blk_serdes_bus_if #(
    parameter int WORD_SIZE = 32
);
    logic [1:0]           op;
    logic [WORD_SIZE-1:0] common_data_bus_write_out;
    logic [WORD_SIZE-1:0] common_data_bus_read_in;
    logic                 ready;
    logic                 tx_done;
    logic                 rd_valid;

    modport master (
        output op, common_data_bus_write_out,
        input  common_data_bus_read_in, ready, tx_done, rd_valid
    );

    modport slave (
        input  op, common_data_bus_write_out,
        output common_data_bus_read_in, ready, tx_done, rd_valid
    );
endinterface

// File: rtl/mem_blk_serdes.sv
// mem_blk_serdes: bridges the memory request arbiter and the memory
// controller's 32-bit common data bus. A write line is sent as two address
// beats followed by 16 data beats; a read line is sent as two address beats
// and then assembled from 16 returned beats.
//
// Ports:
//   clk    clock
//   rst    asynchronous active-low reset
//   reqIf  arbiter side (slave modport of mem_blk_serdes_req_if)
//   busIf  controller side (master modport of mem_blk_serdes_bus_if)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// ADDR_HI   | presenting addr[63:32], waiting for ready
// ADDR_LO   | presenting addr[31:0], waiting for ready
// WR_DATA   | presenting write word[beat], advancing on ready
// RD_DATA   | storing read_in into word[beat] on rd_valid
// WAIT_DONE | all beats moved, waiting for tx_done
// RESP      | one-cycle resp_valid pulse back to the arbiter

module mem_blk_serdes #(
    parameter int WORD_SIZE      = 32,
    parameter int CL_SIZE_WIDTH  = 512,
    parameter int ADDR_BITCOUNT  = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  clk,
    input logic                  rst,
    mem_blk_serdes_req_if.slave  reqIf,
    mem_blk_serdes_bus_if.master busIf
);

    localparam int BEATS  = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int IDX_W  = $clog2(BEATS);
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BEATS);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        WR_DATA,
        RD_DATA,
        WAIT_DONE,
        RESP
    } state_t;

    state_t                   state;
    state_t                   stateNext;
    logic [BEAT_W-1:0]        beatCnt;
    logic [BEAT_W-1:0]        beatCntNext;
    logic [TO_W-1:0]          toCnt;
    logic [TO_W-1:0]          toCntNext;
    logic                     respErr;
    logic                     respErrNext;
    logic                     isWr;
    logic [ADDR_BITCOUNT-1:0] addrReg;
    logic [WORD_SIZE-1:0]     wrWords [BEATS];
    logic [WORD_SIZE-1:0]     rdWords [BEATS];
    logic [CL_SIZE_WIDTH-1:0] rdLineNext;
    logic [CL_SIZE_WIDTH-1:0] respRdata;
    logic [IDX_W-1:0]         wordIdx;
    logic [1:0]               opBusy;
    logic                     storeBeat;
    logic                     progress;
    logic                     busy;

    // beatCnt saturates at BEATS, so the low bits only index a word while a
    // store is still possible.
    assign wordIdx = beatCnt[IDX_W-1:0];
    assign opBusy  = isWr ? OP_WRITE : OP_READ;
    assign busy    = (state != IDLE) && (state != RESP);

    always_comb begin
        stateNext   = state;
        beatCntNext = beatCnt;
        toCntNext   = toCnt;
        respErrNext = respErr;
        storeBeat   = 1'b0;
        progress    = 1'b0;

        busIf.op                        = OP_NOP;
        busIf.common_data_bus_write_out = '0;
        reqIf.req_ready                 = 1'b0;
        reqIf.resp_valid                = 1'b0;

        case (state)
            IDLE: begin
                reqIf.req_ready = 1'b1;
                respErrNext     = 1'b0;
                beatCntNext     = '0;
                toCntNext       = '0;
                if (reqIf.req_valid) begin
                    stateNext = ADDR_HI;
                end
            end

            ADDR_HI: begin
                busIf.op                        = opBusy;
                busIf.common_data_bus_write_out = addrReg[ADDR_BITCOUNT-1 -: WORD_SIZE];
                progress                        = busIf.ready;
                if (busIf.ready) begin
                    stateNext = ADDR_LO;
                end
            end

            ADDR_LO: begin
                busIf.op                        = opBusy;
                busIf.common_data_bus_write_out = addrReg[WORD_SIZE-1:0];
                progress                        = busIf.ready;
                if (busIf.ready) begin
                    stateNext   = isWr ? WR_DATA : RD_DATA;
                    beatCntNext = '0;
                end
            end

            WR_DATA: begin
                busIf.op                        = opBusy;
                busIf.common_data_bus_write_out = wrWords[wordIdx];
                progress                        = busIf.ready | busIf.tx_done;
                if (busIf.ready) begin
                    beatCntNext = beatCnt + 1'b1;
                    if (beatCnt == BEAT_LAST) begin
                        stateNext = busIf.tx_done ? RESP : WAIT_DONE;
                    end
                end
            end

            RD_DATA: begin
                busIf.op = opBusy;
                progress = busIf.rd_valid | busIf.tx_done;
                if (busIf.rd_valid && (beatCnt != BEAT_FULL)) begin
                    storeBeat   = 1'b1;
                    beatCntNext = beatCnt + 1'b1;
                end
                if (storeBeat && (beatCnt == BEAT_LAST)) begin
                    stateNext = busIf.tx_done ? RESP : WAIT_DONE;
                end else if (busIf.tx_done) begin
                    // Controller ended the burst early: short read.
                    stateNext   = RESP;
                    respErrNext = 1'b1;
                end
            end

            WAIT_DONE: begin
                busIf.op = opBusy;
                progress = busIf.tx_done;
                if (busIf.tx_done) begin
                    stateNext = RESP;
                end
            end

            RESP: begin
                reqIf.resp_valid = 1'b1;
                stateNext        = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // Watchdog on the controller: any stalled cycle counts, progress
        // restarts the count, and expiry overrides the state decision above.
        if (busy) begin
            if (progress) begin
                toCntNext = '0;
            end else if (toCnt == TO_LAST) begin
                toCntNext   = '0;
                stateNext   = RESP;
                respErrNext = 1'b1;
            end else begin
                toCntNext = toCnt + 1'b1;
            end
        end
    end

    // Read line as it will look after this cycle, so resp_rdata is already
    // current in the RESP cycle even when the last beat lands on entry.
    always_comb begin
        rdLineNext = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (storeBeat && (int'(wordIdx) == i)) begin
                rdLineNext[i*WORD_SIZE +: WORD_SIZE] = busIf.common_data_bus_read_in;
            end else begin
                rdLineNext[i*WORD_SIZE +: WORD_SIZE] = rdWords[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beatCnt   <= '0;
            toCnt     <= '0;
            respErr   <= 1'b0;
            isWr      <= 1'b0;
            addrReg   <= '0;
            respRdata <= '0;
            for (int i = 0; i < BEATS; i++) begin
                wrWords[i] <= '0;
                rdWords[i] <= '0;
            end
        end else begin
            state   <= stateNext;
            beatCnt <= beatCntNext;
            toCnt   <= toCntNext;
            respErr <= respErrNext;

            if ((state == IDLE) && reqIf.req_valid) begin
                isWr    <= reqIf.req_wr;
                addrReg <= reqIf.req_addr;
                for (int i = 0; i < BEATS; i++) begin
                    wrWords[i] <= reqIf.req_wdata[i*WORD_SIZE +: WORD_SIZE];
                end
            end

            if (storeBeat) begin
                rdWords[wordIdx] <= busIf.common_data_bus_read_in;
            end

            if (busy && !isWr && (stateNext == RESP)) begin
                respRdata <= rdLineNext;
            end
        end
    end

    assign reqIf.resp_err   = respErr & (state == RESP);
    assign reqIf.resp_rdata = respRdata;

endmodule

// File: tb/tb_mem_blk_serdes.sv
// Testbench for mem_blk_serdes: randomized write/read transactions against a
// line-level reference (expected beat list, expected assembled words).

module tb_mem_blk_serdes;

    localparam int WORD_SIZE = 32;
    localparam int CL        = 512;
    localparam int AB        = 64;
    localparam int TO        = 8;
    localparam int BEATS     = CL / WORD_SIZE;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_blk_serdes_req_if #(.CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AB)) reqIf();
    mem_blk_serdes_bus_if #(.WORD_SIZE(WORD_SIZE)) busIf();

    mem_blk_serdes #(
        .WORD_SIZE      (WORD_SIZE),
        .CL_SIZE_WIDTH  (CL),
        .ADDR_BITCOUNT  (AB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .reqIf (reqIf),
        .busIf (busIf)
    );

    int vecCount  = 0;
    int missCount = 0;

    // Expected content of the read assembly: words the controller delivered,
    // older words left untouched by short reads.
    logic [31:0] refWords [BEATS];

    task automatic checkVal(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [CL-1:0] packLine();
        logic [CL-1:0] r;
        r = '0;
        for (int i = 0; i < BEATS; i++) r[i*32 +: 32] = refWords[i];
        return r;
    endfunction

    function automatic logic [CL-1:0] randLine();
        logic [CL-1:0] r;
        r = '0;
        for (int i = 0; i < BEATS; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] randAddr();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle();
        reqIf.req_valid              = 1'b0;
        reqIf.req_wr                 = 1'b0;
        reqIf.req_addr               = '0;
        reqIf.req_wdata              = '0;
        busIf.ready                  = 1'b0;
        busIf.tx_done                = 1'b0;
        busIf.rd_valid               = 1'b0;
        busIf.common_data_bus_read_in = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_req_ready"},  CL'(reqIf.req_ready), CL'(1));
        checkVal({tag, "_resp_valid"}, CL'(reqIf.resp_valid), CL'(0));
        checkVal({tag, "_resp_err"},   CL'(reqIf.resp_err), CL'(0));
        checkVal({tag, "_resp_rdata"}, reqIf.resp_rdata, '0);
        checkVal({tag, "_op"},         CL'(busIf.op), CL'(0));
        checkVal({tag, "_write_out"},  CL'(busIf.common_data_bus_write_out), CL'(0));
    endtask

    task automatic issueReq(input logic wr, input logic [63:0] addr, input logic [CL-1:0] wdata);
        int guard;
        guard = 0;
        reqIf.req_valid = 1'b1;
        reqIf.req_wr    = wr;
        reqIf.req_addr  = addr;
        reqIf.req_wdata = wdata;
        while (reqIf.req_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        checkVal("req_ready", CL'(reqIf.req_ready), CL'(1));
        step();
        reqIf.req_valid = 1'b0;
    endtask

    task automatic doWrite(input logic [63:0] addr, input logic [CL-1:0] line,
                           input int stallBeat, input int stallLen, input bit txWithLast);
        logic [31:0] expBeats [BEATS+2];
        expBeats[0] = addr[63:32];
        expBeats[1] = addr[31:0];
        for (int i = 0; i < BEATS; i++) expBeats[i+2] = line[i*32 +: 32];
        issueReq(1'b1, addr, line);
        for (int b = 0; b < BEATS + 2; b++) begin
            checkVal("wr_beat", CL'(busIf.common_data_bus_write_out), CL'(expBeats[b]));
            checkVal("wr_op", CL'(busIf.op), CL'(2'b10));
            if (b == stallBeat) begin
                for (int s = 0; s < stallLen; s++) begin
                    busIf.ready = 1'b0;
                    step();
                    checkVal("wr_hold", CL'(busIf.common_data_bus_write_out), CL'(expBeats[b]));
                end
            end
            busIf.ready   = 1'b1;
            busIf.tx_done = (b == BEATS + 1) && txWithLast;
            step();
        end
        busIf.ready   = 1'b0;
        busIf.tx_done = 1'b0;
        if (!txWithLast) begin
            checkVal("wr_early_resp", CL'(reqIf.resp_valid), CL'(0));
            busIf.tx_done = 1'b1;
            step();
            busIf.tx_done = 1'b0;
        end
        checkVal("wr_resp_valid", CL'(reqIf.resp_valid), CL'(1));
        checkVal("wr_resp_err", CL'(reqIf.resp_err), CL'(0));
        checkVal("wr_resp_op", CL'(busIf.op), CL'(0));
        step();
        checkVal("wr_idle_ready", CL'(reqIf.req_ready), CL'(1));
        checkVal("wr_single_pulse", CL'(reqIf.resp_valid), CL'(0));
    endtask

    // gapMode: 0 streaming, 1 one idle cycle between beats, 2 random gaps.
    task automatic doRead(input logic [63:0] addr, input int nBeats, input int gapMode,
                          input bit useRand, input logic [31:0] base, input bit txWithLast,
                          output int lat);
        logic [31:0] d;
        int          gap;
        bit          expErr;
        lat    = 0;
        expErr = (nBeats < BEATS);
        issueReq(1'b0, addr, '0);
        lat++;
        for (int b = 0; b < 2; b++) begin
            checkVal("rd_addr_beat", CL'(busIf.common_data_bus_write_out),
                     CL'((b == 0) ? addr[63:32] : addr[31:0]));
            checkVal("rd_op", CL'(busIf.op), CL'(2'b01));
            busIf.ready = 1'b1;
            step();
            lat++;
        end
        busIf.ready = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            gap = (gapMode == 1) ? ((i > 0) ? 1 : 0) :
                  (gapMode == 2) ? int'($urandom_range(0, 1)) : 0;
            for (int g = 0; g < gap; g++) begin
                busIf.rd_valid                = 1'b0;
                busIf.common_data_bus_read_in = $urandom;
                step();
                lat++;
            end
            checkVal("rd_data_wout", CL'(busIf.common_data_bus_write_out), CL'(0));
            d = useRand ? $urandom : 32'(base + 32'(i));
            refWords[i]                   = d;
            busIf.rd_valid                = 1'b1;
            busIf.common_data_bus_read_in = d;
            busIf.tx_done                 = (i == nBeats - 1) && (nBeats == BEATS) && txWithLast;
            step();
            lat++;
        end
        busIf.rd_valid = 1'b0;
        busIf.tx_done  = 1'b0;
        if (nBeats < BEATS) begin
            checkVal("rd_short_early_resp", CL'(reqIf.resp_valid), CL'(0));
            busIf.tx_done = 1'b1;
            step();
            busIf.tx_done = 1'b0;
        end else if (!txWithLast) begin
            // An extra beat after the line is full must not land in word 0.
            busIf.rd_valid                = 1'b1;
            busIf.common_data_bus_read_in = 32'hDEAD_BEEF;
            step();
            busIf.rd_valid = 1'b0;
            checkVal("rd_wait_early_resp", CL'(reqIf.resp_valid), CL'(0));
            busIf.tx_done = 1'b1;
            step();
            busIf.tx_done = 1'b0;
        end
        checkVal("rd_resp_valid", CL'(reqIf.resp_valid), CL'(1));
        checkVal("rd_resp_err", CL'(reqIf.resp_err), CL'(expErr));
        checkVal("rd_resp_rdata", reqIf.resp_rdata, packLine());
        step();
        checkVal("rd_idle_ready", CL'(reqIf.req_ready), CL'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CL-1:0] line;
        int            lat;
        int            cyc;

        driveIdle();
        for (int i = 0; i < BEATS; i++) refWords[i] = '0;
        rst = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;
        step();

        // Directed write, controller always ready, tx_done one cycle later.
        line = '0;
        for (int i = 0; i < BEATS; i++) line[i*32 +: 32] = 32'(32'hA000_0000 + 32'(i));
        doWrite(64'h0000_0001_0000_0040, line, -1, 0, 1'b0);

        // Backpressure on data word 7 (bus beat 9).
        doWrite(randAddr(), randLine(), 9, 3, 1'b0);

        // Random writes, random stall position, tx_done sometimes with last beat.
        repeat (4) begin
            doWrite(randAddr(), randLine(), int'($urandom_range(0, BEATS + 1)),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        // Read with rd_valid every other cycle.
        doRead(randAddr(), BEATS, 1, 1'b0, 32'h5500_0000, 1'b0, lat);
        checkVal("rd_gap_word0", CL'(reqIf.resp_rdata[31:0]), CL'(32'h5500_0000));
        checkVal("rd_gap_word15", CL'(reqIf.resp_rdata[511:480]), CL'(32'h5500_000F));

        // Streaming read with tx_done on the last beat: minimum latency.
        doRead(randAddr(), BEATS, 0, 1'b1, 32'h0, 1'b1, lat);
        checkVal("rd_latency", CL'(lat + 1), CL'(20));

        repeat (3) begin
            doRead(randAddr(), BEATS, 2, 1'b1, 32'h0, 1'($urandom_range(0, 1)), lat);
        end

        // Short read: words 10-15 keep the previous line.
        doRead(randAddr(), 10, 2, 1'b1, 32'h0, 1'b0, lat);

        // Timeout: controller never takes the high address beat.
        issueReq(1'b1, randAddr(), randLine());
        cyc = 0;
        while (reqIf.resp_valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        checkVal("to_cycles", CL'(cyc), CL'(TO));
        checkVal("to_resp_err", CL'(reqIf.resp_err), CL'(1));
        step();
        checkVal("to_idle_ready", CL'(reqIf.req_ready), CL'(1));

        // Reset in the middle of a read, at beat 5.
        issueReq(1'b0, randAddr(), '0);
        busIf.ready = 1'b1;
        step();
        step();
        busIf.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            busIf.rd_valid                = 1'b1;
            busIf.common_data_bus_read_in = $urandom;
            step();
        end
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("midreset");
        driveIdle();
        for (int i = 0; i < BEATS; i++) refWords[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("midreset_no_resp", CL'(reqIf.resp_valid), CL'(0));
        end
        doRead(randAddr(), BEATS, 2, 1'b1, 32'h0, 1'b0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
